branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//   ID-stage SPARC Bicc resolver. Sits directly upstream of the branch reset/flush logic.
//   Evaluates cond (I28:25) against icc and computes the PC-relative target.
//   Applies SPARC annul-bit (I29) semantics and tracks the delay slot.
//   Produces registered taken/target/annul pulses; annul_delay_slot drives the IF/ID flush.
// PARAMETERS
//   ADDR_W    32  PC / target width
//   DISP_W    22  branch displacement width (disp22)
// PORTS
//   clk                input   1       pipeline clock, rising edge
//   system_reset_n     input   1       asynchronous active-low reset
//   stall              input   1       pipeline hold; FSM and output regs freeze
//   id_valid           input   1       ID holds a live (non-bubble) instruction
//   id_branch_instr    input   1       ID instruction is Bicc
//   id_a               input   1       annul bit I29
//   id_cond            input   4       cond field I28:25
//   id_disp            input   DISP_W  disp22 field I21:0
//   id_pc              input   ADDR_W  PC of the ID instruction
//   icc                input   4       {N,Z,V,C} architectural condition codes
//   cc_pending         input   1       an older in-flight instr still writes icc
//   cc_stall           output  1       request pipeline hold (Mealy, combinational)
//   branch_taken       output  1       registered 1-cycle pulse: redirect to target
//   branch_target      output  ADDR_W  registered; valid while branch_taken=1
//   annul_delay_slot   output  1       registered 1-cycle pulse: squash the delay-slot instr
//   in_delay_slot      output  1       registered; ID holds the slot of a resolved branch
//   dcti_err           output  1       registered pulse: branch found in a live delay slot
// BEHAVIOUR
//   Reset: state=IDLE; branch_taken, annul_delay_slot, in_delay_slot, dcti_err = 0.
//     Reset also sets branch_target=0. It is asynchronous and abandons any WAIT_CC.
//   br = id_valid & id_branch_instr.
//   States:
//   - IDLE:
//     - br & cc_pending: go to WAIT_CC; cc_stall=1; no resolution.
//     - br & !cc_pending: resolve with current icc; go to DELAY.
//   - WAIT_CC:
//     - cc_stall=1 while cc_pending.
//     - cc_pending=0: resolve with that cycle's icc; go to DELAY.
//   - DELAY: in_delay_slot=1 for this cycle.
//     - Next unstalled cycle returns to IDLE.
//     - br seen here with the slot annulled: ignored.
//     - br seen here with the slot live: ignored; dcti_err pulses next cycle.
//   - stall=1: state, all registered outputs and pulses hold (pulses stretch).
//     cc_stall is still computed.
//   Condition eval (cond: result), with N,Z,V,C from icc:
//     0 never         8 always
//     1 Z             9 !Z
//     2 Z|(N^V)       A !(Z|(N^V))
//     3 N^V           B !(N^V)
//     4 C|Z           C !(C|Z)
//     5 C             D !C
//     6 N             E !N
//     7 V             F !V
//   Annul rule:
//     - taken: annul = id_a & (cond==4'h8), i.e. "ba,a".
//     - not taken: annul = id_a.
//   Target = id_pc + (sext(id_disp) << 2), modulo 2^ADDR_W (wrap, no overflow flag).
//   Latency: resolution in cycle N (unstalled) -> taken/target/annul valid in N+1.
//     They are 1 cycle wide unless stall stretches them.
//   Resolution in WAIT_CC samples icc and ID fields from the cycle cc_pending falls.
//   id_valid=0 never resolves; !id_branch_instr in IDLE is a no-op.
// TESTING
//   1. be, icc=0100, a=0, pc=0x1000, disp=0x000010 -> N+1: taken=1, target=0x1040, annul=0.
//   2. bne,a, icc=0100 -> N+1: taken=0, annul=1 (not-taken annul).
//   3. ba,a, pc=0x2000, disp=0x3FFFFF -> taken=1, target=0x1FFC, annul=1.
//      bn,a -> taken=0, annul=1.
//   4. bl, cc_pending=1 for 3 cycles, then icc=1000 -> cc_stall=1 for 3 cycles.
//      Resolves on the 4th cycle; taken=1 on the 5th.
//   5. Resolve, then stall=1 for 2 cycles -> taken pulse held 3 cycles.
//      Branch in the live slot -> dcti_err=1, no second taken.
//   6. system_reset_n low in WAIT_CC -> all outputs 0 immediately.
//      On release state=IDLE; a pending branch is re-evaluated only if re-presented.
//   Also sweep all 16 cond x 16 icc against the truth table; disp=0 with pc=0xFFFFFFFC.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// SPARC Bicc resolver in the ID stage: evaluates cond against icc, forms the
// PC-relative target, applies annul-bit semantics and tracks the delay slot.
module branch_resolve_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DISP_W = 22
) (
   input  logic              clk,
   input  logic              system_reset_n,
   input  logic              stall,
   input  logic              id_valid,
   input  logic              id_branch_instr,
   input  logic              id_a,
   input  logic [3:0]        id_cond,
   input  logic [DISP_W-1:0] id_disp,
   input  logic [ADDR_W-1:0] id_pc,
   input  logic [3:0]        icc,
   input  logic              cc_pending,
   output logic              cc_stall,
   output logic              branch_taken,
   output logic [ADDR_W-1:0] branch_target,
   output logic              annul_delay_slot,
   output logic              in_delay_slot,
   output logic              dcti_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_CC = 2'd1,
      DELAY   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                taken_q, taken_d;
   logic                annul_q, annul_d;
   logic                delay_q, delay_d;
   logic                dcti_q, dcti_d;
   logic [ADDR_W-1:0]   target_q, target_d;

   logic                br;
   logic                resolve;
   logic                condTrue;
   logic                ccStallRaw;
   logic [ADDR_W-1:0]   dispExt;
   logic [ADDR_W-1:0]   targetCalc;

   // Bit 3 of cond inverts the base test selected by bits 2:0; icc = {N,Z,V,C}.
   function automatic logic evalCond(input logic [3:0] cond, input logic [3:0] cc);
      logic n, z, v, c, base;
      n = cc[3];
      z = cc[2];
      v = cc[1];
      c = cc[0];
      case (cond[2:0])
         3'd0:    base = 1'b0;
         3'd1:    base = z;
         3'd2:    base = z | (n ^ v);
         3'd3:    base = n ^ v;
         3'd4:    base = c | z;
         3'd5:    base = c;
         3'd6:    base = n;
         default: base = v;
      endcase
      return cond[3] ^ base;
   endfunction

   always_comb begin
      br         = id_valid & id_branch_instr;
      condTrue   = evalCond(id_cond, icc);
      dispExt    = {{(ADDR_W-DISP_W-2){id_disp[DISP_W-1]}}, id_disp, 2'b00};
      targetCalc = id_pc + dispExt;

      state_d    = state_q;
      resolve    = 1'b0;
      ccStallRaw = 1'b0;

      case (state_q)
         IDLE: begin
            if (br) begin
               if (cc_pending) begin
                  ccStallRaw = 1'b1;
                  state_d    = WAIT_CC;
               end else begin
                  resolve = 1'b1;
                  state_d = DELAY;
               end
            end
         end
         WAIT_CC: begin
            if (cc_pending) begin
               ccStallRaw = 1'b1;
            end else if (br) begin
               resolve = 1'b1;
               state_d = DELAY;
            end else begin
               state_d = IDLE;
            end
         end
         DELAY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Held low during reset so every output reads zero while reset is asserted.
      cc_stall = ccStallRaw & system_reset_n;

      taken_d  = resolve & condTrue;
      annul_d  = resolve & (condTrue ? (id_a & (id_cond == 4'h8)) : id_a);
      target_d = resolve ? targetCalc : target_q;
      delay_d  = (state_d == DELAY);
      dcti_d   = (state_q == DELAY) & br & ~annul_q;
   end

   always_ff @(posedge clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
         state_q  <= IDLE;
         taken_q  <= 1'b0;
         annul_q  <= 1'b0;
         delay_q  <= 1'b0;
         dcti_q   <= 1'b0;
         target_q <= '0;
      end else if (!stall) begin
         state_q  <= state_d;
         taken_q  <= taken_d;
         annul_q  <= annul_d;
         delay_q  <= delay_d;
         dcti_q   <= dcti_d;
         target_q <= target_d;
      end
   end

   assign branch_taken     = taken_q;
   assign branch_target    = target_q;
   assign annul_delay_slot = annul_q;
   assign in_delay_slot    = delay_q;
   assign dcti_err         = dcti_q;

endmodule
